// File: rtl/sdram_port_arbiter_if.sv
// Handshake bundle between the three SDRAM requesters, the port arbiter
// and the SDRAM controller. "master" is the requester/controller side,
// "slave" is the arbiter.
interface sdram_port_arbiter_if #(
    parameter int unsigned AW = 25
);
    // Video requester (read only)
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_ack;
    logic          vid_ready;

    // CPU requester
    logic          cpu_req;
    logic [AW-1:0] cpu_addr;
    logic          cpu_rnw;
    logic [7:0]    cpu_din;
    logic          cpu_ack;
    logic          cpu_ready;

    // ROM/cart download requester (write only)
    logic          ld_req;
    logic [AW-1:0] ld_addr;
    logic [7:0]    ld_din;
    logic          ld_ack;
    logic          ld_ready;

    // Toward / from the SDRAM controller
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_rnw;
    logic [7:0]    mem_din;
    logic          mem_ack;
    logic          mem_ready;
    logic          mem_busy;

    // Status
    logic [1:0]    owner;
    logic          timeout_err;

    modport master (
        output vid_req, vid_addr,
        output cpu_req, cpu_addr, cpu_rnw, cpu_din,
        output ld_req, ld_addr, ld_din,
        output mem_ack, mem_ready, mem_busy,
        input  vid_ack, vid_ready,
        input  cpu_ack, cpu_ready,
        input  ld_ack, ld_ready,
        input  mem_req, mem_addr, mem_rnw, mem_din,
        input  owner, timeout_err
    );

    modport slave (
        input  vid_req, vid_addr,
        input  cpu_req, cpu_addr, cpu_rnw, cpu_din,
        input  ld_req, ld_addr, ld_din,
        input  mem_ack, mem_ready, mem_busy,
        output vid_ack, vid_ready,
        output cpu_ack, cpu_ready,
        output ld_ack, ld_ready,
        output mem_req, mem_addr, mem_rnw, mem_din,
        output owner, timeout_err
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Three-way SDRAM port arbiter (video > cpu > loader, with loader
// anti-starvation) issuing one transaction at a time to the controller,
// with a grant-to-completion watchdog.
module sdram_port_arbiter #(
    parameter int unsigned AW         = 25,
    parameter int unsigned STARVE_MAX = 8,
    parameter int unsigned TIMEOUT    = 255
) (
    input logic                 clk,
    input logic                 reset,
    sdram_port_arbiter_if.slave bus
);
    localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam int unsigned TW = 8;
    localparam int unsigned DW = 8;

    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [TW-1:0] TCNT_LAST  = TW'(TIMEOUT - 1);

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_VID  = 2'b01;
    localparam logic [1:0] OWN_CPU  = 2'b10;
    localparam logic [1:0] OWN_LD   = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RDY = 2'd2
    } state_t;

    state_t        state_q,   state_d;
    logic          mem_req_q, mem_req_d;
    logic [AW-1:0] addr_q,    addr_d;
    logic          rnw_q,     rnw_d;
    logic [DW-1:0] din_q,     din_d;
    logic [1:0]    owner_q,   owner_d;
    logic [SW-1:0] starve_q,  starve_d;
    logic [TW-1:0] tcnt_q,    tcnt_d;
    logic          terr_q,    terr_d;
    // Per-requester pulses, bit 0 video, bit 1 cpu, bit 2 loader
    logic [2:0]    ack_q,     ack_d;
    logic [2:0]    rdy_q,     rdy_d;

    logic [2:0]    sel;
    logic          any_req;
    logic          ld_force;
    logic          at_limit;
    logic [SW-1:0] starve_inc;
    logic [TW-1:0] tcnt_inc;

    assign any_req    = bus.vid_req | bus.cpu_req | bus.ld_req;
    assign ld_force   = bus.ld_req && (starve_q == STARVE_LIM);
    assign at_limit   = (tcnt_q == TCNT_LAST);
    assign starve_inc = (starve_q == STARVE_LIM) ? starve_q : starve_q + SW'(1);
    assign tcnt_inc   = tcnt_q + TW'(1);

    // One-hot select of the current owner's ack/ready lines
    always_comb begin
        sel = 3'b000;
        case (owner_q)
            OWN_VID: sel = 3'b001;
            OWN_CPU: sel = 3'b010;
            OWN_LD:  sel = 3'b100;
            default: sel = 3'b000;
        endcase
    end

    // Next-state and next-output logic for the grant/issue/wait sequence
    always_comb begin
        state_d   = state_q;
        mem_req_d = mem_req_q;
        addr_d    = addr_q;
        rnw_d     = rnw_q;
        din_d     = din_q;
        owner_d   = owner_q;
        starve_d  = starve_q;
        tcnt_d    = tcnt_q;
        terr_d    = terr_q;
        ack_d     = 3'b000;
        rdy_d     = 3'b000;

        case (state_q)
            IDLE: begin
                if (!bus.mem_busy && any_req) begin
                    state_d   = ISSUE;
                    mem_req_d = 1'b1;
                    tcnt_d    = '0;
                    if (ld_force || (!bus.vid_req && !bus.cpu_req)) begin
                        owner_d  = OWN_LD;
                        addr_d   = bus.ld_addr;
                        rnw_d    = 1'b0;
                        din_d    = bus.ld_din;
                        starve_d = '0;
                    end else if (bus.vid_req) begin
                        owner_d  = OWN_VID;
                        addr_d   = bus.vid_addr;
                        rnw_d    = 1'b1;
                        din_d    = '0;
                        if (bus.ld_req) begin
                            starve_d = starve_inc;
                        end
                    end else begin
                        owner_d  = OWN_CPU;
                        addr_d   = bus.cpu_addr;
                        rnw_d    = bus.cpu_rnw;
                        din_d    = bus.cpu_din;
                        if (bus.ld_req) begin
                            starve_d = starve_inc;
                        end
                    end
                end
            end

            ISSUE: begin
                tcnt_d = tcnt_inc;
                if (bus.mem_ack) begin
                    mem_req_d = 1'b0;
                    ack_d     = sel;
                    if (bus.mem_ready || at_limit) begin
                        // Completed together with the accept, or out of time
                        rdy_d   = sel;
                        owner_d = OWN_NONE;
                        state_d = IDLE;
                        if (!bus.mem_ready) begin
                            terr_d = 1'b1;
                        end
                    end else begin
                        state_d = WAIT_RDY;
                    end
                end else if (at_limit) begin
                    mem_req_d = 1'b0;
                    ack_d     = sel;
                    rdy_d     = sel;
                    owner_d   = OWN_NONE;
                    terr_d    = 1'b1;
                    state_d   = IDLE;
                end
            end

            WAIT_RDY: begin
                tcnt_d = tcnt_inc;
                if (bus.mem_ready || at_limit) begin
                    rdy_d   = sel;
                    owner_d = OWN_NONE;
                    state_d = IDLE;
                    if (!bus.mem_ready) begin
                        terr_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                owner_d   = OWN_NONE;
            end
        endcase
    end

    // State and registered outputs, synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            addr_q    <= '0;
            rnw_q     <= 1'b1;
            din_q     <= '0;
            owner_q   <= OWN_NONE;
            starve_q  <= '0;
            tcnt_q    <= '0;
            terr_q    <= 1'b0;
            ack_q     <= 3'b000;
            rdy_q     <= 3'b000;
        end else begin
            state_q   <= state_d;
            mem_req_q <= mem_req_d;
            addr_q    <= addr_d;
            rnw_q     <= rnw_d;
            din_q     <= din_d;
            owner_q   <= owner_d;
            starve_q  <= starve_d;
            tcnt_q    <= tcnt_d;
            terr_q    <= terr_d;
            ack_q     <= ack_d;
            rdy_q     <= rdy_d;
        end
    end

    assign bus.vid_ack     = ack_q[0];
    assign bus.cpu_ack     = ack_q[1];
    assign bus.ld_ack      = ack_q[2];
    assign bus.vid_ready   = rdy_q[0];
    assign bus.cpu_ready   = rdy_q[1];
    assign bus.ld_ready    = rdy_q[2];
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_rnw     = rnw_q;
    assign bus.mem_din     = din_q;
    assign bus.owner       = owner_q;
    assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: directed priority/same-cycle/busy/starvation/
// timeout/reset steps plus randomized traffic against a transaction-level model.
module tb_sdram_port_arbiter;
    localparam int unsigned AW         = 25;
    localparam int unsigned STARVE_MAX = 8;
    localparam int unsigned TIMEOUT    = 255;

    logic clk;
    logic reset;
    int   n_chk  = 0;
    int   n_pass = 0;

    sdram_port_arbiter_if #(.AW(AW)) bus ();

    sdram_port_arbiter #(
        .AW(AW),
        .STARVE_MAX(STARVE_MAX),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: outstanding request per requester (0 video, 1 cpu, 2 loader)
    bit            pend   [3];
    logic [AW-1:0] m_addr [3];
    logic [7:0]    m_din  [3];
    bit            m_rnw  [3];
    int            starve;
    int            last_w;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [2:0] acks();
        return {bus.ld_ack, bus.cpu_ack, bus.vid_ack};
    endfunction

    function automatic logic [2:0] readies();
        return {bus.ld_ready, bus.cpu_ready, bus.vid_ready};
    endfunction

    task automatic drive_reqs();
        bus.vid_req  = pend[0];
        bus.vid_addr = m_addr[0];
        bus.cpu_req  = pend[1];
        bus.cpu_addr = m_addr[1];
        bus.cpu_rnw  = m_rnw[1];
        bus.cpu_din  = m_din[1];
        bus.ld_req   = pend[2];
        bus.ld_addr  = m_addr[2];
        bus.ld_din   = m_din[2];
    endtask

    // A requester raises a new request only when it has none outstanding
    task automatic post(input int r, input bit rnw);
        if (!pend[r]) begin
            pend[r]   = 1'b1;
            m_addr[r] = AW'($urandom);
            m_din[r]  = 8'($urandom);
            m_rnw[r]  = (r == 0) ? 1'b1 : (r == 2) ? 1'b0 : rnw;
        end
    endtask

    // Who should win from the outstanding set, and the starvation bookkeeping
    task automatic model_grant();
        last_w = -1;
        if (pend[2] && starve == STARVE_MAX) last_w = 2;
        else if (pend[0]) last_w = 0;
        else if (pend[1]) last_w = 1;
        else if (pend[2]) last_w = 2;
        if (last_w == 2) starve = 0;
        else if (pend[2]) starve = (starve < STARVE_MAX) ? starve + 1 : STARVE_MAX;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_mem_req"},  32'(bus.mem_req),              32'd0);
        chk({tag, "_mem_addr"}, 32'(bus.mem_addr),             32'd0);
        chk({tag, "_mem_rnw"},  32'(bus.mem_rnw),              32'd1);
        chk({tag, "_mem_din"},  32'(bus.mem_din),              32'd0);
        chk({tag, "_pulses"},   32'({acks(), readies()}),      32'd0);
        chk({tag, "_owner"},    32'(bus.owner),                32'd0);
        chk({tag, "_terr"},     32'(bus.timeout_err),          32'd0);
    endtask

    // One full transaction; call at a negedge with the requests already driven
    task automatic do_txn(input int ack_dly, input int rdy_dly, input bit same);
        logic [2:0] oh;
        int         w;
        if (!(pend[0] || pend[1] || pend[2])) begin
            post(1, 1'b1);
            drive_reqs();
        end
        model_grant();
        w  = last_w;
        oh = 3'(3'b001 << w);
        @(negedge clk);
        chk("grant_owner",   32'(bus.owner),    32'(w + 1));
        chk("grant_mem_req", 32'(bus.mem_req),  32'd1);
        chk("grant_addr",    32'(bus.mem_addr), 32'(m_addr[w]));
        chk("grant_rnw",     32'(bus.mem_rnw),  32'(m_rnw[w]));
        if (!m_rnw[w]) chk("grant_din", 32'(bus.mem_din), 32'(m_din[w]));
        for (int i = 0; i < ack_dly; i++) begin
            @(negedge clk);
            chk("issue_hold", 32'({bus.mem_req, acks(), readies()}), 32'(7'b1000000));
        end
        bus.mem_ack   = 1'b1;
        bus.mem_ready = same;
        @(negedge clk);
        bus.mem_ack   = 1'b0;
        bus.mem_ready = 1'b0;
        chk("ack_pulse",   32'(acks()),      32'(oh));
        chk("ack_mem_req", 32'(bus.mem_req), 32'd0);
        pend[w] = 1'b0;
        drive_reqs();
        if (same) begin
            chk("same_ready", 32'(readies()), 32'(oh));
            chk("same_owner", 32'(bus.owner), 32'd0);
            return;
        end
        chk("ack_no_ready", 32'(readies()), 32'd0);
        for (int i = 0; i < rdy_dly; i++) begin
            @(negedge clk);
            chk("wait_quiet", 32'({acks(), readies()}), 32'd0);
            chk("wait_addr",  32'(bus.mem_addr),        32'(m_addr[w]));
            chk("wait_owner", 32'(bus.owner),           32'(w + 1));
        end
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        chk("ready_pulse",  32'(readies()),  32'(oh));
        chk("ready_no_ack", 32'(acks()),     32'd0);
        chk("ready_owner",  32'(bus.owner),  32'd0);
    endtask

    task automatic rand_txn();
        for (int r = 0; r < 3; r++)
            if (!pend[r] && $urandom_range(0, 1) == 1) post(r, 1'($urandom_range(0, 1)));
        drive_reqs();
        if ($urandom_range(0, 3) == 0) begin
            bus.mem_busy = 1'b1;
            repeat ($urandom_range(1, 4)) begin
                @(negedge clk);
                chk("rand_busy_hold", 32'({bus.owner, bus.mem_req}), 32'd0);
            end
            bus.mem_busy = 1'b0;
        end
        do_txn(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
    endtask

    initial begin
        int       cnt;
        int       hi;
        logic [2:0] oh;

        reset         = 1'b1;
        bus.mem_ack   = 1'b0;
        bus.mem_ready = 1'b0;
        bus.mem_busy  = 1'b0;
        for (int r = 0; r < 3; r++) begin
            pend[r]   = 1'b0;
            m_addr[r] = '0;
            m_din[r]  = '0;
            m_rnw[r]  = 1'b1;
        end
        starve = 0;
        last_w = -1;
        drive_reqs();
        repeat (3) @(negedge clk);
        check_reset_state("init");
        reset = 1'b0;

        // Controller pulses while idle are ignored
        bus.mem_ack   = 1'b1;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ack   = 1'b0;
        bus.mem_ready = 1'b0;
        chk("spurious_idle", 32'({acks(), readies(), bus.owner, bus.mem_req}), 32'd0);

        // Video beats cpu; cpu granted right after return to idle
        post(0, 1'b1);
        post(1, 1'b1);
        drive_reqs();
        do_txn(0, 0, 1'b0);
        do_txn(1, 2, 1'b0);

        // CPU write with accept and completion in the same cycle, then immediate regrant
        post(1, 1'b0);
        drive_reqs();
        do_txn(2, 0, 1'b1);
        post(0, 1'b1);
        drive_reqs();
        do_txn(0, 1, 1'b0);

        // Controller busy holds off the grant
        post(1, 1'b1);
        drive_reqs();
        bus.mem_busy = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("busy_hold", 32'({bus.owner, bus.mem_req}), 32'd0);
        end
        bus.mem_busy = 1'b0;
        do_txn(0, 0, 1'b0);

        // Loader held while video keeps requesting: STARVE_MAX video grants then loader, twice
        for (int round = 0; round < 2; round++) begin
            cnt = 0;
            post(2, 1'b0);
            for (int i = 0; i < int'(STARVE_MAX) + 2; i++) begin
                post(0, 1'b1);
                drive_reqs();
                do_txn(0, 0, 1'b0);
                if (last_w == 2) break;
                cnt++;
            end
            chk("starve_video_grants", 32'(cnt), 32'(STARVE_MAX));
            chk("starve_loader_won",   32'(last_w), 32'd2);
            pend[0] = 1'b0;
            drive_reqs();
        end

        // Randomized traffic
        repeat (60) rand_txn();

        // Flush outstanding requests so the cpu timeout transaction is alone
        while (pend[0] || pend[1] || pend[2]) do_txn(0, 0, 1'b0);

        // Timeout: cpu read never accepted
        post(1, 1'b1);
        drive_reqs();
        model_grant();
        oh = 3'b010;
        @(negedge clk);
        chk("to_grant_owner", 32'(bus.owner), 32'd2);
        hi = 0;
        for (int i = 1; i < int'(TIMEOUT); i++) begin
            @(negedge clk);
            if (bus.mem_req === 1'b1 && acks() == 3'b000) hi++;
        end
        chk("to_req_held", 32'(hi), 32'(TIMEOUT - 1));
        @(negedge clk);
        chk("to_mem_req", 32'(bus.mem_req),     32'd0);
        chk("to_ack",     32'(acks()),          32'(oh));
        chk("to_ready",   32'(readies()),       32'(oh));
        chk("to_err",     32'(bus.timeout_err), 32'd1);
        chk("to_owner",   32'(bus.owner),       32'd0);
        pend[1] = 1'b0;
        drive_reqs();
        @(negedge clk);
        chk("to_single_pulse", 32'({acks(), readies()}), 32'd0);

        repeat (5) rand_txn();
        chk("to_err_sticky", 32'(bus.timeout_err), 32'd1);

        // Reset while waiting for completion
        post(0, 1'b1);
        drive_reqs();
        model_grant();
        oh = 3'(3'b001 << last_w);
        @(negedge clk);
        chk("rst_pre_owner", 32'(bus.owner), 32'(last_w + 1));
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk("rst_pre_ack", 32'(acks()), 32'(oh));
        for (int r = 0; r < 3; r++) pend[r] = 1'b0;
        drive_reqs();
        reset = 1'b1;
        @(negedge clk);
        check_reset_state("rst_wait");
        reset  = 1'b0;
        starve = 0;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        chk("rst_late_ready", 32'({acks(), readies(), bus.owner, bus.mem_req}), 32'd0);
        @(negedge clk);
        chk("rst_quiet", 32'({acks(), readies(), bus.owner, bus.mem_req}), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
